// File: rtl/seq_chunk_subtractor_pkg.sv
// Shared types and elaboration helpers for the chunked multi-cycle subtractor.
package seq_chunk_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int num_chunks(input int data_wid, input int chunk_wid);
        return data_wid / chunk_wid;
    endfunction

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_chunk_subtractor_sub_chunk.sv
// Combinational subtract slice: A + ~B + ~BorrowIn, borrow reported as inverted carry.
module seq_chunk_subtractor_sub_chunk #(
    parameter int WID = 16
) (
    input  logic [WID-1:0] A,
    input  logic [WID-1:0] B,
    input  logic           BorrowIn,
    output logic [WID-1:0] Diff,
    output logic           BorrowOut
);

    logic [WID-1:0] b_inv;
    logic [WID:0]   carry;

    assign b_inv = ~B;

    always_comb begin
        carry[0] = ~BorrowIn;
        for (int i = 0; i < WID; i++) begin
            Diff[i]      = A[i] ^ b_inv[i] ^ carry[i];
            carry[i + 1] = (A[i] & b_inv[i]) | (A[i] & carry[i]) | (b_inv[i] & carry[i]);
        end
    end

    assign BorrowOut = ~carry[WID];

endmodule

// File: rtl/seq_chunk_subtractor.sv
// Multi-cycle subtractor: CHUNK_WID bits per clock, borrow registered between chunks,
// valid/ready handshakes on both sides.
module seq_chunk_subtractor
    import seq_chunk_subtractor_pkg::*;
#(
    parameter int DATA_WID  = 64,
    parameter int CHUNK_WID = 16
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                InValid,
    output logic                InReady,
    input  logic [DATA_WID-1:0] Minuend,
    input  logic [DATA_WID-1:0] Subtrahend,
    input  logic                BorrowInput,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [DATA_WID-1:0] Difference,
    output logic                BorrowOutput,
    output logic                Overflow
);

    localparam int              NUM_CHUNKS = num_chunks(DATA_WID, CHUNK_WID);
    localparam int              IDX_W      = idx_width(NUM_CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CHUNKS - 1);
    localparam int              MSB        = DATA_WID - 1;

    generate
        if (DATA_WID % CHUNK_WID != 0) begin : g_bad_chunk_wid
            $error("seq_chunk_subtractor: DATA_WID must be a multiple of CHUNK_WID");
        end
    endgenerate

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                borrow_q, borrow_d;
    logic [DATA_WID-1:0] a_q, a_d;
    logic [DATA_WID-1:0] b_q, b_d;
    logic [DATA_WID-1:0] res_q, res_d;
    logic                borrow_out_q, borrow_out_d;
    logic                overflow_q, overflow_d;

    logic [CHUNK_WID-1:0] chunk_a, chunk_b, chunk_diff;
    logic                 chunk_borrow;

    assign chunk_a = a_q[idx_q * CHUNK_WID +: CHUNK_WID];
    assign chunk_b = b_q[idx_q * CHUNK_WID +: CHUNK_WID];

    seq_chunk_subtractor_sub_chunk #(
        .WID (CHUNK_WID)
    ) u_sub_chunk (
        .A         (chunk_a),
        .B         (chunk_b),
        .BorrowIn  (borrow_q),
        .Diff      (chunk_diff),
        .BorrowOut (chunk_borrow)
    );

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case leaves one unassigned, which would infer a latch.
        state_d      = state_q;
        idx_d        = idx_q;
        borrow_d     = borrow_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        borrow_out_d = borrow_out_q;
        overflow_d   = overflow_q;

        unique case (state_q)
            IDLE: begin
                if (InValid) begin
                    a_d      = Minuend;
                    b_d      = Subtrahend;
                    borrow_d = BorrowInput;
                    idx_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                res_d[idx_q * CHUNK_WID +: CHUNK_WID] = chunk_diff;
                borrow_d = chunk_borrow;
                idx_d    = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d      = DONE;
                    borrow_out_d = chunk_borrow;
                    // The top chunk's MSB is the result sign bit.
                    overflow_d   = (a_q[MSB] != b_q[MSB]) && (chunk_diff[CHUNK_WID-1] != a_q[MSB]);
                end
            end
            DONE: begin
                if (OutReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            borrow_q     <= 1'b0;
            res_q        <= '0;
            borrow_out_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            borrow_q     <= borrow_d;
            res_q        <= res_d;
            borrow_out_q <= borrow_out_d;
            overflow_q   <= overflow_d;
        end
    end

    // NOTE: operand registers are pure datapath, always loaded on accept before use, so they carry no reset.
    always_ff @(posedge Clock) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign InReady      = (state_q == IDLE) && Reset_n;
    assign OutValid     = (state_q == DONE);
    assign Difference   = res_q;
    assign BorrowOutput = borrow_out_q;
    assign Overflow     = overflow_q;

endmodule
